// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the round-robin ALU scheduler.
package alu_sched_pkg;

  localparam int WIDTH     = 8;
  localparam int CMD_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [CMD_WIDTH-1:0] CMD_MUL_INC = 4'd9;
  localparam logic [CMD_WIDTH-1:0] CMD_MUL_SHL = 4'd10;

  localparam int FLG_COUT  = 5;
  localparam int FLG_OFLOW = 4;
  localparam int FLG_E     = 3;
  localparam int FLG_G     = 2;
  localparam int FLG_L     = 1;
  localparam int FLG_ERR   = 0;

  function automatic logic is_mul(input logic mode, input logic [CMD_WIDTH-1:0] cmd);
    return mode && ((cmd == CMD_MUL_INC) || (cmd == CMD_MUL_SHL));
  endfunction

endpackage

// File: rtl/alu_rr_sched_if.sv
// ALU input/result bus between the scheduler (master) and the shared ALU (slave).
interface alu_rr_sched_if;
  import alu_sched_pkg::*;

  logic [WIDTH-1:0]     OPA;
  logic [WIDTH-1:0]     OPB;
  logic [CMD_WIDTH-1:0] CMD;
  logic [1:0]           INP_VALID;
  logic                 CE;
  logic                 CIN;
  logic                 MODE;
  logic [WIDTH:0]       RES;
  logic                 COUT;
  logic                 OFLOW;
  logic                 E;
  logic                 G;
  logic                 L;
  logic                 ERR;

  modport master (
    output OPA, OPB, CMD, INP_VALID, CE, CIN, MODE,
    input  RES, COUT, OFLOW, E, G, L, ERR
  );

  modport slave (
    input  OPA, OPB, CMD, INP_VALID, CE, CIN, MODE,
    output RES, COUT, OFLOW, E, G, L, ERR
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at the pointer and wraps; the pointer
// moves past the winner only when the grant is actually taken.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    id,
  output logic               any
);

  logic [ID_W-1:0] ptr_r;
  logic [ID_W-1:0] cand_s;

  // pointer register
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (advance) begin
      ptr_r <= (id == ID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
    end
  end

  // search downward so the candidate closest to the pointer is written last
  always_comb begin
    id     = '0;
    any    = 1'b0;
    cand_s = '0;
    grant  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_s = ID_W'((int'(ptr_r) + k) % NUM_REQ);
      if (req[cand_s]) begin
        id  = cand_s;
        any = 1'b1;
      end else begin
        id  = id;
        any = any;
      end
    end
    if (any) begin
      grant[id] = 1'b1;
    end else begin
      grant = '0;
    end
  end

endmodule

// File: rtl/alu_rr_sched.sv
// Shares one ALU among NUM_REQ requesters: one operation in flight, issued
// with CE, held for the command's latency, result returned to its owner.
module alu_rr_sched
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 3
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]     req_opa,
  input  logic [NUM_REQ*WIDTH-1:0]     req_opb,
  input  logic [NUM_REQ*CMD_WIDTH-1:0] req_cmd,
  input  logic [NUM_REQ-1:0]           req_mode,
  input  logic [NUM_REQ-1:0]           req_cin,
  input  logic [NUM_REQ*2-1:0]         req_inp_valid,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [WIDTH:0]               rsp_res,
  output logic [5:0]                   rsp_flags,
  alu_rr_sched_if.master               alu
);

  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MAX_LAT = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  state_e               state_r, state_nxt;
  logic [NUM_REQ-1:0]   grant_s;
  logic [ID_W-1:0]      win_id_s;
  logic                 any_s;
  logic                 accept_s;
  logic [ID_W-1:0]      id_r;
  logic [CNT_W-1:0]     lat_cnt_r;
  logic [WIDTH-1:0]     opa_r, opb_r;
  logic [CMD_WIDTH-1:0] cmd_r;
  logic [1:0]           inp_valid_r;
  logic                 ce_r, cin_r, mode_r;
  logic [WIDTH:0]       res_r;
  logic [5:0]           flags_r, flags_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clk     (CLK),
    .rst     (RST),
    .req     (req_valid),
    .advance (accept_s),
    .grant   (grant_s),
    .id      (win_id_s),
    .any     (any_s)
  );

  assign accept_s       = (state_r == IDLE) && any_s && !RST;
  assign alu.OPA        = opa_r;
  assign alu.OPB        = opb_r;
  assign alu.CMD        = cmd_r;
  assign alu.INP_VALID  = inp_valid_r;
  assign alu.CE         = ce_r;
  assign alu.CIN        = cin_r;
  assign alu.MODE       = mode_r;
  assign rsp_res        = res_r;
  assign rsp_flags      = flags_r;

  // state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE:    state_nxt = accept_s ? ISSUE : IDLE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = (lat_cnt_r == '0) ? RESP : WAIT;
      RESP:    state_nxt = rsp_ready[id_r] ? IDLE : RESP;
      default: state_nxt = IDLE;
    endcase
  end

  // handshake outputs decoded from state
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if ((state_r == IDLE) && !RST) begin
      req_ready = grant_s;
    end else begin
      req_ready = '0;
    end
    if (state_r == RESP) begin
      rsp_valid[id_r] = 1'b1;
    end else begin
      rsp_valid = '0;
    end
  end

  // ALU flag bus gathered into response order
  always_comb begin
    flags_s            = '0;
    flags_s[FLG_COUT]  = alu.COUT;
    flags_s[FLG_OFLOW] = alu.OFLOW;
    flags_s[FLG_E]     = alu.E;
    flags_s[FLG_G]     = alu.G;
    flags_s[FLG_L]     = alu.L;
    flags_s[FLG_ERR]   = alu.ERR;
  end

  // operand latch, ALU drive, latency counter and result capture
  always_ff @(posedge CLK) begin
    if (RST) begin
      id_r        <= '0;
      lat_cnt_r   <= '0;
      opa_r       <= '0;
      opb_r       <= '0;
      cmd_r       <= '0;
      inp_valid_r <= 2'b00;
      ce_r        <= 1'b0;
      cin_r       <= 1'b0;
      mode_r      <= 1'b0;
      res_r       <= '0;
      flags_r     <= 6'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            id_r        <= win_id_s;
            opa_r       <= req_opa[int'(win_id_s)*WIDTH +: WIDTH];
            opb_r       <= req_opb[int'(win_id_s)*WIDTH +: WIDTH];
            cmd_r       <= req_cmd[int'(win_id_s)*CMD_WIDTH +: CMD_WIDTH];
            inp_valid_r <= req_inp_valid[int'(win_id_s)*2 +: 2];
            cin_r       <= req_cin[win_id_s];
            mode_r      <= req_mode[win_id_s];
            ce_r        <= 1'b1;
          end
        end
        ISSUE: begin
          lat_cnt_r <= is_mul(mode_r, cmd_r) ? CNT_W'(MUL_LAT - 1) : CNT_W'(ALU_LAT - 1);
        end
        WAIT: begin
          if (lat_cnt_r == '0) begin
            res_r   <= alu.RES;
            flags_r <= flags_s;
            ce_r    <= 1'b0;
          end else begin
            lat_cnt_r <= lat_cnt_r - 1'b1;
          end
        end
        RESP: begin
          ce_r <= 1'b0;
        end
        default: begin
          ce_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_rr_sched.md
Name: alu_rr_sched

Overview:
- Round-robin scheduler that shares one ALU instance between NUM_REQ requesters.
- Accepts one operation at a time from a valid/ready request port and drives the ALU input bus (OPA/OPB/CMD/INP_VALID/CE/CIN/MODE).
- Waits the command-dependent ALU latency, captures RES and flags, and returns them on a response port to the granted requester.
- Sits between the test/bus-side masters and the ALU DUT.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ALU_LAT, 1, cycles after the ALU sampling edge until RES/flags are stable, for non-multiply commands (>=1).
- MUL_LAT, 3, the same latency for multiply commands: MODE=1 and CMD in {9,10} (>=1).

Widths WIDTH and CMD_WIDTH come from the shared defines.

Ports:
- CLK  in  1  clock; all logic on posedge
- RST  in  1  synchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  one-hot accept; combinational from state, req_valid and pointer
- req_opa  in  NUM_REQ*WIDTH  operand A, slice i belongs to requester i
- req_opb  in  NUM_REQ*WIDTH  operand B
- req_cmd  in  NUM_REQ*CMD_WIDTH  command
- req_mode  in  NUM_REQ  1 = arithmetic, 0 = logical
- req_cin  in  NUM_REQ  carry in
- req_inp_valid  in  NUM_REQ*2  operand-valid bits
- rsp_valid  out  NUM_REQ  one-hot response valid
- rsp_ready  in  NUM_REQ  response accept
- rsp_res  out  WIDTH+1  captured RES
- rsp_flags  out  6  {COUT,OFLOW,E,G,L,ERR}
- OPA, OPB  out  WIDTH  to ALU
- CMD  out  CMD_WIDTH  to ALU
- INP_VALID  out  2  to ALU
- CE, CIN, MODE  out  1  to ALU
- RES  in  WIDTH+1  from ALU
- COUT, OFLOW, E, G, L, ERR  in  1  from ALU

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP.
- Reset (synchronous, from any state, including mid-WAIT or mid-RESP):
  - state=IDLE, pointer=0, lat_cnt=0.
  - All ALU-side outputs=0 (CE=0).
  - rsp_valid=0, rsp_res=0, rsp_flags=0, req_ready=0.
  - An in-flight operation is discarded with no response.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching from pointer upward, wrapping mod NUM_REQ.
  - req_ready[winner]=1; all other bits 0. If no req_valid, req_ready=0.
  - On handshake: latch the winner's fields and id, set pointer=(winner+1) mod NUM_REQ, go to ISSUE.
- ISSUE (1 cycle):
  - Drive latched fields onto ALU outputs with CE=1.
  - Load lat_cnt = (MODE && CMD in {9,10}) ? MUL_LAT-1 : ALU_LAT-1.
  - Go to WAIT.
- WAIT:
  - CE stays 1; ALU inputs held stable.
  - If lat_cnt==0: capture RES and flags into rsp_res/rsp_flags, go to RESP. Otherwise decrement lat_cnt.
- RESP:
  - CE=0; OPA/OPB/CMD hold their last values.
  - rsp_valid[id]=1, and rsp_res/rsp_flags held stable until rsp_ready[id]=1.
  - On that handshake: rsp_valid=0 next cycle, go to IDLE.
  - rsp_ready on any other bit is ignored.
- req_ready is 0 in every state except IDLE, so at most one operation is in flight.
- Latency, accept edge at cycle 0:
  - ISSUE in cycle 1; WAIT in cycles 2..1+LAT.
  - rsp_valid first high in cycle 2+LAT: cycle 3 for ALU_LAT=1, cycle 5 for MUL_LAT=3.
  - Minimum spacing between accepts is LAT+3 cycles.
- Field forwarding: INP_VALID, CIN, MODE and CMD are passed through unmodified.
  - Illegal CMD or INP_VALID=00 is not filtered; the ALU's ERR is returned in rsp_flags[0].
- The pointer advances only on an accepted grant. With a single active requester, that requester is re-granted every turn.
- A requester that drops req_valid before its grant simply loses the grant; no state changes.

Decomposition:
- Package alu_sched_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, RESP};
  - constants CMD_MUL_INC=9, CMD_MUL_SHL=10;
  - flag bit indices FLG_COUT=5 down to FLG_ERR=0.
- Sub-module rr_arbiter (NUM_REQ) owns the pointer and produces the one-hot grant and binary id from req_valid. It has an advance input pulsed on handshake.
- The scheduler FSM, operand latch and latency counter stay in alu_rr_sched.

Test Plan:
- Single request: requester 0 sends OPA=8'h05, OPB=8'h03, MODE=1, CMD=0 (ADD), INP_VALID=11. Expect CE=1 in cycles 1–2, rsp_valid[0] in cycle 3, rsp_res=9'h008, flags ERR=0.
- Simultaneous requests: req_valid=2'b11 held after reset. Expect grants in order 0, 1, 0, 1, and each response is returned only to its own rsp_valid bit.
- Multiply latency: MODE=1, CMD=9, OPA=3, OPB=4. Expect CE high for cycles 1–4 and rsp_valid in cycle 5, with RES captured from the ALU on the last WAIT edge.
- Backpressure: hold rsp_ready[1]=0 for 10 cycles. Expect rsp_valid[1] and rsp_res stable throughout, req_ready=0 throughout, and a new grant only in the cycle after rsp_ready[1]=1.
- Reset mid-operation: assert RST during WAIT. Next cycle expect CE=0 and rsp_valid=0. With req_valid=2'b11, the first grant after reset goes to requester 0.
- Error passthrough: INP_VALID=00, CMD=0. Expect a response with rsp_flags[0]=1 mirroring the ALU's ERR, at normal latency.
